// File: rtl/shifter_2d_mc.sv
// Multi-lane tapped delay line with per-lane registered taps, rotate mode and occupancy tracking.
// Latency: in -> stage s at edge k+s, on salida at k+s+1; no backpressure (enable strobes shifts); optional SHIFTER_2D_DROP_CNT_EN.
module shifter_2d_mc #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  localparam int SELW = $clog2(DEPTH),
  localparam int OCCW = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   modo,
  input  logic                   recirc,
  input  logic [LANES*SELW-1:0]  seleccion,
  input  logic [LANES*WIDTH-1:0] entrada_serie,
  input  logic                   entrada_valid,
  output logic [LANES*WIDTH-1:0] salida_serie,
  output logic [LANES-1:0]       salida_valid,
  output logic [OCCW-1:0]        occupancy,
  output logic                   full,
  output logic [15:0]            drop_count
);

  localparam logic [SELW-1:0] LAST = SELW'(DEPTH - 1);

  logic [LANES*WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0]       v_q;
  logic [LANES*WIDTH-1:0] tap_dat;
  logic [LANES-1:0]       tap_vld;
  logic                   in_vld;
  logic [OCCW-1:0]        occ_nxt;

  // Tap index per lane; out-of-range selects fall back to the last stage.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SELW-1:0] sel;
    logic [SELW-1:0] tap;
    assign sel = seleccion[i*SELW +: SELW];
    assign tap = !modo ? LAST : ((32'(sel) >= DEPTH) ? LAST : sel);
    assign tap_dat[i*WIDTH +: WIDTH] = stage_q[tap][i*WIDTH +: WIDTH];
    assign tap_vld[i] = v_q[tap];
  end

  assign in_vld  = recirc ? v_q[DEPTH-1] : entrada_valid;
  assign occ_nxt = recirc ? occupancy
                          : occupancy + OCCW'(entrada_valid) - OCCW'(v_q[DEPTH-1]);
  assign full    = (occupancy == OCCW'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      v_q          <= '0;
      salida_serie <= '0;
      salida_valid <= '0;
      occupancy    <= '0;
    end else if (!clear) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      v_q          <= '0;
      salida_serie <= '0;
      salida_valid <= '0;
      occupancy    <= '0;
    end else begin
      // Output taps sample every cycle, independent of enable.
      salida_serie <= tap_dat;
      salida_valid <= tap_vld;
      if (enable) begin
        for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        stage_q[0] <= recirc ? stage_q[DEPTH-1] : entrada_serie;
        v_q        <= {v_q[DEPTH-2:0], in_vld};
        occupancy  <= occ_nxt;
      end
    end
  end

`ifdef SHIFTER_2D_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (!clear) begin
      drop_q <= '0;
    end else if (enable && !recirc && v_q[DEPTH-1] && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_shifter_2d_mc.sv
// Directed bench for shifter_2d_mc: a DEPTH=4 instance plus a DEPTH=5 instance for tap clamping.
module tb_shifter_2d_mc;

`ifdef SHIFTER_2D_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        modo;
  logic        recirc;
  logic [3:0]  seleccion;
  logic [5:0]  seleccion5;
  logic [15:0] entrada_serie;
  logic        entrada_valid;

  logic [15:0] salida_serie;
  logic [1:0]  salida_valid;
  logic [2:0]  occupancy;
  logic        full;
  logic [15:0] drop_count;

  logic [15:0] salida5;
  logic [1:0]  sv5;
  logic [2:0]  occ5;
  logic        full5;
  logic [15:0] drop5;

  int n_tests = 0;
  int n_fail  = 0;

  shifter_2d_mc #(.DEPTH(4), .WIDTH(8), .LANES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .modo(modo), .recirc(recirc), .seleccion(seleccion),
    .entrada_serie(entrada_serie), .entrada_valid(entrada_valid),
    .salida_serie(salida_serie), .salida_valid(salida_valid),
    .occupancy(occupancy), .full(full), .drop_count(drop_count)
  );

  shifter_2d_mc #(.DEPTH(5), .WIDTH(8), .LANES(2)) dut5 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .modo(modo), .recirc(recirc), .seleccion(seleccion5),
    .entrada_serie(entrada_serie), .entrada_valid(entrada_valid),
    .salida_serie(salida5), .salida_valid(sv5),
    .occupancy(occ5), .full(full5), .drop_count(drop5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear  = 1'b0;
    enable = 1'b0;
    tick();
    clear  = 1'b1;
  endtask

  int occ_exp [5] = '{1, 1, 1, 1, 0};

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b1; modo = 1'b0; recirc = 1'b0;
    seleccion = '0; seleccion5 = '0; entrada_serie = '0; entrada_valid = 1'b0;
    #12 reset = 1'b1;

    // 1: reset state
    tick();
    chk("rst_salida", salida_serie, 16'h0000);
    chk("rst_valid", salida_valid, 2'b00);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_drop", drop_count, 16'h0000);

    // 2: single word travels to the last stage
    enable = 1'b1; entrada_valid = 1'b1; entrada_serie = {8'hB1, 8'hA1};
    tick();
    chk("lat_occ0", occupancy, 3'(occ_exp[0]));
    entrada_valid = 1'b0; entrada_serie = '0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("lat_occ%0d", i), occupancy, 3'(occ_exp[i]));
      if (i == 3) chk("lat_early_valid", salida_valid, 2'b00);
    end
    chk("lat_salida", salida_serie, 16'hB1A1);
    chk("lat_valid", salida_valid, 2'b11);
    chk("lat_drop", drop_count, 16'(DROP_ON));

    // 3: fill, then per-lane taps with shifting stopped
    pulse_clear();
    chk("clr_occ", occupancy, 3'd0);
    chk("clr_drop", drop_count, 16'h0000);
    enable = 1'b1; entrada_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      entrada_serie = {8'h20 + 8'(i), 8'h10 + 8'(i)};
      tick();
    end
    enable = 1'b0; entrada_valid = 1'b0; modo = 1'b1; seleccion = {2'd3, 2'd0};
    tick();
    chk("tap_salida", salida_serie, 16'h2013);
    chk("tap_valid", salida_valid, 2'b11);
    chk("tap_full", full, 1'b1);
    chk("tap_occ", occupancy, 3'd4);

    // 4: rotate a full line once around
    modo = 1'b0; recirc = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rot_out%0d", i), salida_serie, {8'h20 + 16'(i), 8'h10 + 8'(i)});
      chk($sformatf("rot_occ%0d", i), occupancy, 3'd4);
    end
    chk("rot_drop", drop_count, 16'h0000);
    enable = 1'b0; modo = 1'b1; seleccion = {2'd3, 2'd0};
    tick();
    chk("rot_order", salida_serie, 16'h2013);
    recirc = 1'b0; enable = 1'b1; entrada_valid = 1'b1; entrada_serie = 16'h3433;
    tick();
    chk("drop_one", drop_count, 16'(DROP_ON));
    chk("drop_occ", occupancy, 3'd4);
    enable = 1'b0; entrada_valid = 1'b0;

    // 5: DEPTH=5 instance, select beyond the last stage clamps
    pulse_clear();
    modo = 1'b0; enable = 1'b1; entrada_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      entrada_serie = {8'h50 + 8'(i), 8'h40 + 8'(i)};
      tick();
    end
    enable = 1'b0; entrada_valid = 1'b0; modo = 1'b1; seleccion5 = {3'd1, 3'd5};
    tick();
    chk("clamp5_a", salida5, 16'h5340);
    chk("clamp5_valid", sv5, 2'b11);
    chk("clamp5_full", full5, 1'b1);
    chk("clamp5_occ", occ5, 3'd5);
    seleccion5 = {3'd7, 3'd4};
    tick();
    chk("clamp7_b", salida5, 16'h5040);

    // 6: synchronous clear during continuous shifting
    modo = 1'b0; enable = 1'b1; entrada_valid = 1'b1; entrada_serie = 16'h6261;
    tick();
    tick();
    clear = 1'b0;
    tick();
    chk("sclr_salida", salida_serie, 16'h0000);
    chk("sclr_valid", salida_valid, 2'b00);
    chk("sclr_occ", occupancy, 3'd0);
    chk("sclr_full", full, 1'b0);
    chk("sclr_drop", drop_count, 16'h0000);
    clear = 1'b1; entrada_serie = 16'h6665;
    tick();
    chk("resume_occ", occupancy, 3'd1);
    entrada_valid = 1'b0; entrada_serie = '0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("resume_bubble%0d", i), salida_valid, 2'b00);
    end
    tick();
    chk("resume_salida", salida_serie, 16'h6665);
    chk("resume_valid", salida_valid, 2'b11);
    chk("resume_occ_end", occupancy, 3'd0);

    // async reset mid-shift
    modo = 1'b1; seleccion = 4'b0000; entrada_valid = 1'b1; entrada_serie = 16'h7776;
    tick();
    tick();
    chk("pre_arst_salida", salida_serie, 16'h7776);
    chk("pre_arst_occ", occupancy, 3'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_salida", salida_serie, 16'h0000);
    chk("arst_valid", salida_valid, 2'b00);
    chk("arst_occ", occupancy, 3'd0);
    chk("arst_full5", full5, 1'b0);
    chk("arst_drop", drop_count, 16'h0000);
    enable = 1'b0; entrada_valid = 1'b0;
    #2 reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
